// File: rtl/alu_div32.sv
// Radix-2 restoring integer divider, one quotient bit per cycle.
// Signed operands are reduced to magnitudes on entry and the signs are
// restored in a two-cycle FIX phase. Divide-by-zero skips the iteration.
module alu_div32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Two's-complement negation, modulo 2^WIDTH (MIN maps to itself).
  function automatic logic [WIDTH-1:0] neg_mod(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] n;
    n = -x;
    return n;
  endfunction

  // Negate only when the sign flag asks for it.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? neg_mod(x) : x;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             fix_last;
  logic             accept;
  logic             b_zero;

  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dvs_p0;
  logic [WIDTH-1:0] dvd_p0;
  logic             qneg_p0;
  logic             rneg_p0;
  logic             dz_p0;

  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] rem_p1;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_dif;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             ge;

  // A request is taken only in a genuine idle cycle, never in the Done cycle.
  assign accept = (state == IDLE) && Start && !Done;
  assign b_zero = (B == '0);

  // One restoring step: shift {R,Q} left, subtract D when the widened R covers it.
  always_comb begin
    rem_sh  = {rem_p0, quo_p0[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, dvs_p0});
    rem_dif = rem_sh[WIDTH-1:0] - dvs_p0;
    rem_nxt = ge ? rem_dif : rem_sh[WIDTH-1:0];
    quo_nxt = {quo_p0[WIDTH-2:0], ge};
  end

  // Stage p0: operand capture and iteration; stage p1: sign-corrected results.
  always_ff @(posedge Clk) begin
    if (accept) begin
      quo_p0  <= cond_neg(A, Signed & A[WIDTH-1]);
      dvs_p0  <= cond_neg(B, Signed & B[WIDTH-1]);
      rem_p0  <= '0;
      dvd_p0  <= A;
      qneg_p0 <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      rneg_p0 <= Signed & A[WIDTH-1];
      dz_p0   <= b_zero;
    end else if (state == CALC) begin
      rem_p0  <= rem_nxt;
      quo_p0  <= quo_nxt;
    end else if (state == FIX && !fix_last) begin
      quo_p1  <= dz_p0 ? '1 : cond_neg(quo_p0, qneg_p0);
      rem_p1  <= dz_p0 ? dvd_p0 : cond_neg(rem_p0, rneg_p0);
    end
  end

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      fix_last  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            Busy     <= 1'b1;
            fix_last <= 1'b0;
            if (b_zero) begin
              state <= FIX;
              cnt   <= '0;
            end else begin
              state <= CALC;
              cnt   <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (!fix_last) begin
            fix_last <= 1'b1;
          end else begin
            fix_last  <= 1'b0;
            state     <= IDLE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Quotient  <= quo_p1;
            Remainder <= rem_p1;
            DivByZero <= dz_p0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
